// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide execute unit: radix-2 shift-add multiply, restoring divide.
// Start/busy/done handshake; divide-by-zero and signed overflow resolve in a one-cycle fast path.
module muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   CntLast = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e state_q, state_d;

    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // Multiplicand for MUL*, divisor for DIV*/REM*.
    logic [XLEN-1:0]   opr_q, opr_d;
    // Product accumulator; for divides the low half holds dividend bits shifting out, quotient in.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Decode and operand conditioning at accept
    logic            is_mop;
    logic            accept;
    logic            is_div;
    logic [2:0]      f3;
    logic            signed_a, signed_b;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            b_zero, ovf, fast;
    logic [XLEN-1:0] fast_res;
    logic            unused_inst;

    assign f3     = inst[14:12];
    assign is_mop = (inst[6:0] == 7'b0110011) && (inst[31:25] == 7'b0000001);
    assign accept = (state_q == StIdle) && start && is_mop && !flush;
    assign is_div = f3[2];

    assign unused_inst = ^{inst[24:15], inst[11:7]};

    assign signed_a = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
    assign signed_b = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
    assign sign_a   = signed_a && op_a[XLEN-1];
    assign sign_b   = signed_b && op_b[XLEN-1];
    assign mag_a    = sign_a ? -op_a : op_a;
    assign mag_b    = sign_b ? -op_b : op_b;

    assign b_zero = (op_b == '0);
    assign ovf    = !f3[0] && (op_a == MinNeg) && (op_b == AllOnes);
    assign fast   = is_div && (b_zero || ovf);

    always_comb begin
        fast_res = '0;
        if (b_zero) begin
            fast_res = f3[1] ? op_a : AllOnes;
        end else begin
            fast_res = f3[1] ? '0 : op_a;
        end
    end

    // Iteration datapath
    logic [XLEN-1:0] mul_addend;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;

    assign mul_addend = acc_q[0] ? opr_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    // Trial subtraction is XLEN+1 wide; the top bit is the borrow that rejects the step.
    assign div_shift  = {rem_q, acc_q[XLEN-1]};
    assign div_diff   = div_shift - {1'b0, opr_q};

    // Sign fix-up and half selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_res;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = neg_q ? -rem_q : rem_q;

    always_comb begin
        fix_res = '0;
        case (f3_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    // Control FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = fast ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == CntLast) begin
                    state_d = StFix;
                end
            end
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next-state
    always_comb begin
        f3_d     = f3_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        opr_d    = opr_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    f3_d  = f3;
                    neg_d = (f3 == 3'b110) ? sign_a : (sign_a ^ sign_b);
                    cnt_d = '0;
                    rem_d = '0;
                    opr_d = is_div ? mag_b : mag_a;
                    acc_d = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    if (fast) begin
                        result_d = fast_res;
                    end
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CW'(1);
                if (f3_q[2]) begin
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN]};
                    rem_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
            end
            StFix: begin
                if (!flush) begin
                    result_d = fix_res;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            opr_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            opr_q    <= opr_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed RV32M cases plus randomized traffic against a
// cycle-level reference model computed with plain 64-bit arithmetic.
module tb_muldiv_seq;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic            clk;
    logic            rst;
    logic            start;
    logic            flush;
    logic [31:0]     inst;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    int vectors = 0;
    int errors  = 0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .inst   (inst),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic is_mop(input logic [31:0] w);
        return (w[6:0] == 7'b0110011) && (w[31:25] == 7'b0000001);
    endfunction

    function automatic logic [31:0] mk_inst(input logic [2:0] f3);
        logic [31:0] w;
        w        = $urandom;
        w[31:25] = 7'b0000001;
        w[14:12] = f3;
        w[6:0]   = 7'b0110011;
        return w;
    endfunction

    // RISC-V M-extension semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
        if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return LAT;
    endfunction

    // Reference model: outstanding op counts down to its done cycle.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend = '0;
    int          m_left = 0;

    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_left = 0;
            end else if (flush) begin
                m_busy = 1'b0; m_done = 1'b0;
            end else if (m_done) begin
                m_busy = 1'b0; m_done = 1'b0;
            end else if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1; m_result = m_pend;
                end
            end else if (start && is_mop(inst)) begin
                m_busy = 1'b1;
                m_pend = ref_op(inst[14:12], op_a, op_b);
                m_left = lat_of(inst[14:12], op_a, op_b) - 1;
                if (m_left == 0) begin
                    m_done = 1'b1; m_result = m_pend;
                end
            end
            #1;
            chk("model busy", {31'b0, busy}, {31'b0, m_busy});
            chk("model done", {31'b0, done}, {31'b0, m_done});
            chk("model result", result, m_result);
        end
    end

    // Called at a negedge in IDLE; returns at the negedge after done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string nm,
                          input int poke);
        int cyc;
        int nbusy;
        start = 1'b1; inst = mk_inst(f3); op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0; inst = $urandom; op_a = $urandom; op_b = $urandom;
        cyc = 1; nbusy = 0;
        while (1) begin
            if (busy) nbusy++;
            if (done || cyc >= 60) break;
            @(negedge clk);
            cyc++;
            start = (cyc == poke);
            if (cyc == poke) begin
                inst = mk_inst(3'b000); op_a = 32'd100; op_b = 32'd100;
            end
        end
        start = 1'b0;
        chk({nm, " done cycle"}, cyc, lat);
        chk({nm, " result"}, result, exp);
        chk({nm, " busy cycles"}, nbusy, lat);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom % 5)
            0: v = $urandom % 16;
            1: v = -($urandom % 16);
            2, 3: v = $urandom;
            default: begin
                case ($urandom % 4)
                    0: v = 32'h0000_0000;
                    1: v = 32'h8000_0000;
                    2: v = 32'h7FFF_FFFF;
                    default: v = 32'hFFFF_FFFF;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin : stimulus
        int nd;
        rst = 1'b0; start = 1'b0; flush = 1'b0; inst = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        rst = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, "mul 7*-3", 0);
        run_op(3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT, "mulh 7*-3", 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, "mulhu", 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT, "mulhsu", 0);
        run_op(3'd4, 32'd12345, 32'd0, 32'hFFFF_FFFF, 1, "div by 0", 0);
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, "remu by 0", 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div ovf", 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem ovf", 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT, "div -7/2", 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT, "rem -7/2", 0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, LAT, "divu 100/7", 0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, LAT, "remu 100/7", 0);

        // Flush a DIV during cycle 15, then start a MUL on the next cycle.
        start = 1'b1; inst = mk_inst(3'd4); op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {31'b0, busy}, 32'd0);
        chk("flush done", {31'b0, done}, 32'd0);
        chk("flush result kept", result, 32'd2);
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, "mul after flush", 0);

        // Second start at cycle 10 of a running MUL must be ignored.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, "mul poke", 10);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("poke extra done", nd, 0);

        // Non-M instruction is ignored.
        start = 1'b1; inst = 32'h0000_0033; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            chk("non-M busy", {31'b0, busy}, 32'd0);
            chk("non-M done", {31'b0, done}, 32'd0);
            @(negedge clk);
        end

        // Asynchronous reset at cycle 20 of a MULHU.
        start = 1'b1; inst = mk_inst(3'd3); op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(3'd0, 32'd3, 32'd5, 32'd15, LAT, "mul 3*5", 0);

        // Randomized traffic with stray starts, flushes and non-M instructions.
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int          k;
            f3 = 3'($urandom);
            a  = rnd_opnd();
            b  = rnd_opnd();
            if ($urandom % 8 == 0) b = 32'd0;
            if ($urandom % 10 == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            inst  = ($urandom % 10 == 0) ? 32'($urandom) : mk_inst(f3);
            op_a  = a;
            op_b  = b;
            start = 1'b1;
            flush = ($urandom % 16 == 0);
            @(negedge clk);
            start = 1'b0;
            flush = 1'b0;
            k = 0;
            while (busy && k < 50) begin
                start = ($urandom % 6 == 0);
                inst  = mk_inst(3'($urandom));
                op_a  = $urandom;
                op_b  = $urandom;
                flush = ($urandom % 100 == 0);
                @(negedge clk);
                k++;
            end
            start = 1'b0;
            flush = 1'b0;
            chk("random drain", {31'b0, busy}, 32'd0);
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide execute unit, parametrised in operand width, alongside the single-cycle ALU in the EX stage.
- Decodes the M-extension funct3 from the instruction word and runs a radix-2 shift-add multiply or restoring divide over XLEN cycles.
- Uses a start/busy/done handshake so the pipeline can stall on it.
- Handles RISC-V divide-by-zero and signed-overflow results in a one-cycle fast path.

Parameters:
XLEN, 32, operand/result width in bits (even, >=8)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE and only when inst is an M-op
flush  input  1  synchronous abort; returns to IDLE, no done pulse
inst  input  32  instruction word; opcode [6:0], funct3 [14:12], funct7 [31:25]
op_a  input  XLEN  rs1 value, sampled with accepted start
op_b  input  XLEN  rs2 value, sampled with accepted start
busy  output  1  high from the cycle after accept until the cycle done is high
done  output  1  one-cycle pulse; result valid this cycle
result  output  XLEN  result; holds last value until the next done

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, result=0, all datapath registers 0. Reset mid-operation discards the operation silently.
- M-op means inst[6:0]=0110011 and inst[31:25]=0000001. A start with a non-M inst is ignored: no state change, no done.
- funct3 decode:
  - 000 MUL: low product.
  - 001 MULH: signed x signed, high.
  - 010 MULHSU: signed x unsigned, high.
  - 011 MULHU: unsigned x unsigned, high.
  - 100 DIV, 101 DIVU.
  - 110 REM, 111 REMU.
- States: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on accepted start. Latch funct3, then take magnitudes of the signed operands and record the sign flags: neg_res = sign_a^sign_b for MUL*/DIV; for REM, neg_res = sign_a.
  - IDLE -> DONE (fast path) on accepted start when:
    - div/rem with op_b=0: DIV/DIVU result all-ones; REM/REMU result op_a.
    - DIV/REM with op_a=2^(XLEN-1) and op_b=all-ones: DIV result op_a; REM result 0.
  - CALC: iteration counter runs 0..XLEN-1, one bit per cycle.
    - Multiply: 2*XLEN accumulator, shift-add.
    - Divide: restoring; remainder XLEN+1 bits, quotient shifts in.
    - CALC -> FIX when counter = XLEN-1.
  - FIX: conditional two's-complement negate (2*XLEN for product, XLEN for quotient/remainder), select high/low half. -> DONE.
  - DONE: result registered, done=1 for exactly this cycle. -> IDLE.
- Latency, accept cycle = 0:
  - Normal: done at cycle XLEN+2 (34 for XLEN=32). Back-to-back throughput is one op per XLEN+3 cycles.
  - Fast path: done at cycle 1.
- busy=1 in CALC and FIX, and in DONE. busy=0 in IDLE.
- start while busy is ignored. No queueing; the pipeline holds the instruction.
- flush has priority over all transitions:
  - From any state, next state is IDLE, busy=0 the next cycle, and done is suppressed.
  - result keeps its previous value.
  - flush and start in the same IDLE cycle: start is ignored.
- done and a new accepted start never coincide, because start is only sampled in IDLE.
- Operands are sampled once; changes to op_a/op_b/inst after accept have no effect.

Test Plan:
- MUL 7 x -3 (op_a=7, op_b=0xFFFFFFFD, funct3=000) -> done at cycle 34, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with busy high cycles 1..34 and done only at cycle 34.
- Fast paths:
  - DIV x/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, done at cycle 1.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM same operands -> 0, done at cycle 1.
- Handshake:
  - start with inst[31:25]=0000000 -> no busy, no done.
  - start pulsed again at cycle 10 of a running MUL -> ignored, single done, result unchanged by the second operands.
- flush at cycle 15 of a DIV -> IDLE next cycle, no done, result keeps prior value; new MUL started at the following cycle completes correctly.
- rst asserted at cycle 20 of MULHU -> busy=0, done=0, result=0 immediately; after release, a fresh MUL 3x5 -> 15.
